// File: rtl/sky_pixel_writer.sv
// Framebuffer writer for the sky/shading colour path: 4x4 ordered dither,
// 24-bit {B,G,R} to BGR555, one word per pixel with a single bubble-collapsing output register.
//
// state | meaning
// IDLE  | waiting for start; base address captured on start
// RUN   | accepting colours, one write per accepted pixel
// DRAIN | last pixel accepted; holding its write until the framebuffer takes it
module sky_pixel_writer #(
    parameter int WIDTH     = 200,
    parameter int HEIGHT    = 160,
    parameter int ADDR_BITS = 16,
    parameter bit DITHER_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [23:0]          in_colour,
    output logic                 fb_write,
    input  logic                 fb_ready,
    output logic [ADDR_BITS-1:0] fb_addr,
    output logic [15:0]          fb_data,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int XW = (WIDTH  > 4) ? $clog2(WIDTH)      : 2;
    localparam int YW = (HEIGHT > 4) ? $clog2(HEIGHT + 1) : 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]           state;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [ADDR_BITS-1:0] addr_cnt;
    logic                 in_hs;
    logic                 fb_acc;
    logic                 last_px;
    logic [2:0]           m_half;
    logic [2:0]           dith;
    logic [15:0]          pix_bgr;

    assign in_ready   = (state == S_RUN) && (!fb_write || fb_ready);
    assign in_hs      = in_valid && in_ready;
    assign fb_acc     = fb_write && fb_ready;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DRAIN) && fb_acc;
    assign last_px    = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));

    // Bayer matrix already halved, so the offset range is 0..7.
    always_comb begin
        m_half = 3'd0;
        case ({y[1:0], x[1:0]})
            4'h0: m_half = 3'd0;  4'h1: m_half = 3'd4;  4'h2: m_half = 3'd1;  4'h3: m_half = 3'd5;
            4'h4: m_half = 3'd6;  4'h5: m_half = 3'd2;  4'h6: m_half = 3'd7;  4'h7: m_half = 3'd3;
            4'h8: m_half = 3'd1;  4'h9: m_half = 3'd5;  4'hA: m_half = 3'd0;  4'hB: m_half = 3'd4;
            4'hC: m_half = 3'd7;  4'hD: m_half = 3'd3;  4'hE: m_half = 3'd6;  4'hF: m_half = 3'd2;
            default: m_half = 3'd0;
        endcase
    end

    assign dith = DITHER_EN ? m_half : 3'd0;

    function automatic logic [4:0] chan5(input logic [7:0] c, input logic [2:0] d);
        logic [8:0] s;
        s = {1'b0, c} + {6'd0, d};
        return s[8] ? 5'h1F : s[7:3];
    endfunction

    assign pix_bgr = {1'b0, chan5(in_colour[23:16], dith),
                      chan5(in_colour[15:8], dith), chan5(in_colour[7:0], dith)};

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            addr_cnt <= '0;
            fb_write <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_cnt <= base_addr;
                        x        <= '0;
                        y        <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_hs) begin
                        fb_write <= 1'b1;
                        fb_addr  <= addr_cnt;
                        fb_data  <= pix_bgr;
                        addr_cnt <= addr_cnt + 1'b1;
                        if (x == XW'(WIDTH - 1)) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                        if (last_px)
                            state <= S_DRAIN;
                    end else if (fb_acc) begin
                        fb_write <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (fb_acc) begin
                        fb_write <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sky_pixel_writer.sv
// Bench for sky_pixel_writer: directed pixels with hand-computed words plus a
// cycle-level scoreboard over two full-handshake instances (dither on and off).
module tb_sky_pixel_writer;

    localparam int W = 200;
    localparam int H = 160;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic        in_valid;
    logic [23:0] in_colour;
    logic        fb_ready;
    logic        in_ready, fb_write, busy, frame_done;
    logic [15:0] fb_addr, fb_data;
    logic        nd_in_ready, nd_fb_write, nd_busy, nd_frame_done;
    logic [15:0] nd_fb_addr, nd_fb_data;

    sky_pixel_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_BITS(16), .DITHER_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_colour(in_colour),
        .fb_write(fb_write), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
        .busy(busy), .frame_done(frame_done)
    );

    sky_pixel_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_BITS(16), .DITHER_EN(1'b0)) dut_nd (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(nd_in_ready), .in_colour(in_colour),
        .fb_write(nd_fb_write), .fb_ready(fb_ready), .fb_addr(nd_fb_addr), .fb_data(nd_fb_data),
        .busy(nd_busy), .frame_done(nd_frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    int mtab[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    function automatic logic [15:0] exp_px(input logic [23:0] c, input int px, input int py, input bit den);
        int d, r, g, b;
        d = den ? (mtab[(py % 4) * 4 + (px % 4)] >> 1) : 0;
        r = int'(c[7:0]) + d;   if (r > 255) r = 255;
        g = int'(c[15:8]) + d;  if (g > 255) g = 255;
        b = int'(c[23:16]) + d; if (b > 255) b = 255;
        return {1'b0, 5'(b >> 3), 5'(g >> 3), 5'(r >> 3)};
    endfunction

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] data_nd;
    } exp_t;

    exp_t        q[$];
    int          m_state = 0;   // 0 idle, 1 run, 2 drain
    int          mx = 0, my = 0;
    logic [15:0] m_addr = 16'h0;
    bit          m_valid = 1'b0;
    int          writes = 0, dones = 0;
    bit          exp_ir, acc;

    // Reference model: checks outputs for the cycle just finished, then steps on the inputs for the next edge.
    always @(negedge clock) begin
        exp_ir = (m_state == 1) && ((q.size() == 0) || fb_ready);
        if (m_valid) begin
            check("in_ready", in_ready, exp_ir);
            check("fb_write", fb_write, q.size() != 0);
            check("busy", busy, m_state != 0);
            check("frame_done", frame_done, (m_state == 2) && (q.size() != 0) && fb_ready);
            check("nd_fb_write", nd_fb_write, q.size() != 0);
            if (q.size() != 0) begin
                check("fb_addr", fb_addr, q[0].addr);
                check("fb_data", fb_data, q[0].data);
                check("nd_fb_data", nd_fb_data, q[0].data_nd);
            end
        end
        if (reset) begin
            m_state = 0;
            q.delete();
            mx = 0;
            my = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            acc = (q.size() != 0) && fb_ready;
            if (m_state == 0) begin
                if (start) begin
                    m_state = 1;
                    m_addr  = base_addr;
                    mx = 0;
                    my = 0;
                end
            end else begin
                if (acc) begin
                    void'(q.pop_front());
                    writes++;
                    if (m_state == 2) begin
                        dones++;
                        m_state = 0;
                    end
                end
                if (m_state == 1 && in_valid && exp_ir) begin
                    q.push_back('{m_addr, exp_px(in_colour, mx, my, 1'b1), exp_px(in_colour, mx, my, 1'b0)});
                    m_addr = m_addr + 16'd1;
                    if (mx == W - 1 && my == H - 1) m_state = 2;
                    if (mx == W - 1) begin
                        mx = 0;
                        my++;
                    end else begin
                        mx++;
                    end
                end
            end
        end
    end

    bit rdy_rand = 1'b0;
    bit rdy_val  = 1'b0;

    initial begin
        fb_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            fb_ready = rdy_rand ? ($urandom_range(7) != 0) : rdy_val;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns 1 ns after the handshake edge; in_valid is left asserted.
    task automatic send_px(input logic [23:0] c);
        int t = 0;
        in_valid  = 1'b1;
        in_colour = c;
        @(negedge clock);
        while (!in_ready && t < 1000) begin
            t++;
            @(negedge clock);
        end
        check("hs_timeout", in_ready, 1'b1);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = 16'h0;
        in_valid  = 1'b0;
        in_colour = 24'h0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_fb_write", fb_write, 1'b0);
        check("rst_fb_addr", fb_addr, 16'h0);
        check("rst_fb_data", fb_data, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        reset = 1'b0;
        tick();

        start = 1'b1;
        base_addr = 16'h1000;
        rdy_val = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clock);
        check("start_busy", busy, 1'b1);
        check("start_in_ready", in_ready, 1'b1);
        tick();

        send_px(24'hBE8000);
        check("px0_addr", fb_addr, 16'h1000);
        check("px0_data", fb_data, 16'h5E00);
        check("px0_nd_data", nd_fb_data, 16'h5E00);
        send_px(24'hBE8000);
        check("px1_addr", fb_addr, 16'h1001);
        check("px1_data", fb_data, 16'h6200);
        check("px1_nd_data", nd_fb_data, 16'h5E00);
        for (int n = 2; n < 5; n++) send_px(24'h123456);
        send_px(24'h000007);
        check("px5_data", fb_data, 16'h0001);
        check("px5_nd_data", nd_fb_data, 16'h0000);
        for (int n = 6; n < 10; n++) send_px(24'h0A0B0C);
        send_px(24'h404040);

        rdy_val = 1'b0;
        in_colour = 24'h102030;
        repeat (5) begin
            @(negedge clock);
            check("stall_addr", fb_addr, 16'h100A);
            check("stall_data", fb_data, 16'h2108);
            check("stall_write", fb_write, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
        end
        tick();
        rdy_val  = 1'b1;
        rdy_rand = 1'b1;

        for (int n = 11; n <= 500; n++) begin
            if (n == 300) start = 1'b1;
            send_px(24'($urandom));
            start = 1'b0;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("midrst_fb_write", fb_write, 1'b0);
        check("midrst_frame_done", frame_done, 1'b0);
        check("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        writes = 0;
        dones  = 0;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < W * H; n++) begin
            send_px((n == 603) ? 24'hFFFFFF : 24'($urandom));
            if (n == 0) check("restart_addr", fb_addr, 16'h1000);
            if (n == 603) begin
                check("sat_data", fb_data, 16'h7FFF);
                check("sat_nd_data", nd_fb_data, 16'h7FFF);
            end
        end
        in_valid = 1'b0;
        begin
            int t = 0;
            while (dones == 0 && t < 200) begin
                tick();
                t++;
            end
        end
        repeat (3) tick();
        check("frame_writes", writes, W * H);
        check("frame_dones", dones, 1);
        check("end_busy", busy, 1'b0);
        check("end_fb_write", fb_write, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
